// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcodes, funct3 codes, memory-stage state type and helpers
package core_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [63:0] RESET_PC = 64'h80000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // funct3[1:0] encodes access size for both loads and stores
  function automatic logic is_aligned(input logic [2:0] f3, input logic [2:0] addr);
    logic ok;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~addr[0];
      2'b10:   ok = (addr[1:0] == 2'b00);
      default: ok = (addr == 3'b000);
    endcase
    return ok;
  endfunction

  // byte enables for a store of the given size at the given byte lane
  function automatic logic [7:0] store_mask(input logic [2:0] f3, input logic [2:0] addr);
    logic [7:0] base;
    case (f3[1:0])
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << addr;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - shift bus read data to byte lane 0 and sign/zero-extend
module mem_load_align
  import core_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  addr,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  logic [63:0] x;

  assign x = rdata >> {addr, 3'b000};

  // select extension by load type; LD and unknown codes pass the shifted word
  always_comb begin
    data = x;
    case (funct3)
      F3_B:    data = {{56{x[7]}},  x[7:0]};
      F3_H:    data = {{48{x[15]}}, x[15:0]};
      F3_W:    data = {{32{x[31]}}, x[31:0]};
      F3_BU:   data = {56'd0, x[7:0]};
      F3_HU:   data = {48'd0, x[15:0]};
      F3_WU:   data = {32'd0, x[31:0]};
      default: data = x;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV64 memory stage: classify, run dmem req/ack, format load data
module mem_access_unit
  import core_pkg::*;
#(
  parameter logic [63:0] RESET_PC = core_pkg::RESET_PC,
  parameter int          XLEN     = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            mem_allowin,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [31:0]     ex_inst,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [1:0]      ex_sel_rfres,
  output logic            mem_valid,
  input  logic            wb_allowin,
  output logic [XLEN-1:0] mem_pc,
  output logic [31:0]     mem_inst,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [1:0]      mem_sel_rfres,
  output logic [XLEN-1:0] mem_rdata,
  output logic            mem_misalign,
  output logic            dmem_req,
  output logic            dmem_wen,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wmask,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata
);

  mem_state_t state, state_nxt;

  logic        accept;
  logic        ex_is_load;
  logic        ex_is_store;
  logic        ex_aligned;
  logic        ex_go_bus;
  logic [63:0] load_fmt;

  assign ex_is_load  = (ex_inst[6:0] == OPC_LOAD);
  assign ex_is_store = (ex_inst[6:0] == OPC_STORE);
  assign ex_aligned  = is_aligned(ex_inst[14:12], ex_alu_result[2:0]);
  assign ex_go_bus   = (ex_is_load | ex_is_store) & ex_aligned;

  assign mem_allowin = (state == IDLE) | ((state == DONE) & wb_allowin);
  assign accept      = ex_valid & mem_allowin;
  assign mem_valid   = (state == DONE);
  assign dmem_req    = (state == BUS);

  // formatting uses the latched instruction and address, not the EX inputs
  mem_load_align u_load_align (
    .rdata  (dmem_rdata),
    .addr   (mem_alu_result[2:0]),
    .funct3 (mem_inst[14:12]),
    .data   (load_fmt)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state: a handoff in DONE may overlap with the next accept
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = ex_go_bus ? BUS : DONE;
      BUS:  if (dmem_ack) state_nxt = DONE;
      DONE: if (wb_allowin) state_nxt = accept ? (ex_go_bus ? BUS : DONE) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // payload and bus-field registers; held unchanged except on accept or ack
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_pc         <= RESET_PC;
      mem_inst       <= '0;
      mem_alu_result <= '0;
      mem_sel_rfres  <= '0;
      mem_rdata      <= '0;
      mem_misalign   <= 1'b0;
      dmem_wen       <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_wmask     <= '0;
    end else if (accept) begin
      mem_pc         <= ex_pc;
      mem_inst       <= ex_inst;
      mem_alu_result <= ex_alu_result;
      mem_sel_rfres  <= ex_sel_rfres;
      mem_rdata      <= '0;
      mem_misalign   <= (ex_is_load | ex_is_store) & ~ex_aligned;
      dmem_wen       <= ex_is_store;
      dmem_addr      <= {ex_alu_result[63:3], 3'b000};
      dmem_wdata     <= ex_store_data << {ex_alu_result[2:0], 3'b000};
      dmem_wmask     <= store_mask(ex_inst[14:12], ex_alu_result[2:0]);
    end else if ((state == BUS) && dmem_ack) begin
      if (mem_inst[6:0] == OPC_LOAD) mem_rdata <= load_fmt;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        mem_allowin;
  logic [63:0] ex_pc;
  logic [31:0] ex_inst;
  logic [63:0] ex_alu_result;
  logic [63:0] ex_store_data;
  logic [1:0]  ex_sel_rfres;
  logic        mem_valid;
  logic        wb_allowin;
  logic [63:0] mem_pc;
  logic [31:0] mem_inst;
  logic [63:0] mem_alu_result;
  logic [1:0]  mem_sel_rfres;
  logic [63:0] mem_rdata;
  logic        mem_misalign;
  logic        dmem_req;
  logic        dmem_wen;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wmask;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] I_ADD = 32'h00208033;
  localparam logic [31:0] I_LB  = 32'h00000083;
  localparam logic [31:0] I_LBU = 32'h00004083;
  localparam logic [31:0] I_SH  = 32'h00001023;
  localparam logic [31:0] I_LW  = 32'h00002083;
  localparam logic [31:0] I_LD  = 32'h00003083;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .mem_allowin    (mem_allowin),
    .ex_pc          (ex_pc),
    .ex_inst        (ex_inst),
    .ex_alu_result  (ex_alu_result),
    .ex_store_data  (ex_store_data),
    .ex_sel_rfres   (ex_sel_rfres),
    .mem_valid      (mem_valid),
    .wb_allowin     (wb_allowin),
    .mem_pc         (mem_pc),
    .mem_inst       (mem_inst),
    .mem_alu_result (mem_alu_result),
    .mem_sel_rfres  (mem_sel_rfres),
    .mem_rdata      (mem_rdata),
    .mem_misalign   (mem_misalign),
    .dmem_req       (dmem_req),
    .dmem_wen       (dmem_wen),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wmask     (dmem_wmask),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // present an instruction from EX; the caller's next posedge accepts it
  task automatic drive(input logic [63:0] pc, input logic [31:0] inst,
                       input logic [63:0] alu, input logic [63:0] sd);
    ex_valid      = 1'b1;
    ex_pc         = pc;
    ex_inst       = inst;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_sel_rfres  = 2'b01;
  endtask

  // all drives and samples happen at the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  // in BUS: wait `waits` cycles checking req holds, then ack with rd
  task automatic bus_ack(input int waits, input logic [63:0] rd, input string tag);
    for (int i = 0; i < waits; i++) begin
      step();
      chk({tag, "_req_hold"}, {63'd0, dmem_req}, 64'd1);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = rd;
    step();
    dmem_ack   = 1'b0;
    dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_pc = '0; ex_inst = '0; ex_alu_result = '0;
    ex_store_data = '0; ex_sel_rfres = '0; wb_allowin = 1'b1; dmem_ack = 1'b0;
    dmem_rdata = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid",   {63'd0, mem_valid},   64'd0);
    chk("rst_pc",      mem_pc,               64'h80000000);
    chk("rst_req",     {63'd0, dmem_req},    64'd0);
    chk("rst_allowin", {63'd0, mem_allowin}, 64'd1);
    chk("rst_rdata",   mem_rdata,            64'd0);
    chk("rst_wmask",   {56'd0, dmem_wmask},  64'd0);

    // non-memory instruction: valid one cycle after accept, no bus traffic
    drive(64'h80000100, I_ADD, 64'h1234, 64'd0);
    step();
    ex_valid = 1'b0;
    chk("add_valid", {63'd0, mem_valid}, 64'd1);
    chk("add_alu",   mem_alu_result,     64'h1234);
    chk("add_rdata", mem_rdata,          64'd0);
    chk("add_req",   {63'd0, dmem_req},  64'd0);
    chk("add_mis",   {63'd0, mem_misalign}, 64'd0);
    step();
    chk("add_gone",  {63'd0, mem_valid}, 64'd0);
    chk("add_req2",  {63'd0, dmem_req},  64'd0);

    // LB at byte 3, ack after 3 cycles, sign-extended 0x80
    drive(64'h80000104, I_LB, 64'h80001003, 64'd0);
    step();
    ex_valid = 1'b0;
    chk("lb_req",   {63'd0, dmem_req}, 64'd1);
    chk("lb_addr",  dmem_addr,         64'h80001000);
    chk("lb_wen",   {63'd0, dmem_wen}, 64'd0);
    chk("lb_noval", {63'd0, mem_valid}, 64'd0);
    bus_ack(2, 64'h00000000_80FF0000, "lb");
    chk("lb_valid", {63'd0, mem_valid}, 64'd1);
    chk("lb_rdata", mem_rdata,          64'hFFFFFFFF_FFFFFF80);
    chk("lb_reqlo", {63'd0, dmem_req},  64'd0);
    step();

    // LBU at the same address: zero-extended
    drive(64'h80000108, I_LBU, 64'h80001003, 64'd0);
    step();
    ex_valid = 1'b0;
    bus_ack(0, 64'h00000000_80FF0000, "lbu");
    chk("lbu_rdata", mem_rdata, 64'h80);
    step();

    // SH to byte 6: mask and data on the upper lanes, held until ack
    drive(64'h8000010C, I_SH, 64'h80001006, 64'hABCD);
    step();
    ex_valid = 1'b0;
    chk("sh_wen",   {63'd0, dmem_wen},   64'd1);
    chk("sh_wmask", {56'd0, dmem_wmask}, 64'hC0);
    chk("sh_wdata", dmem_wdata,          64'hABCD0000_00000000);
    chk("sh_addr",  dmem_addr,           64'h80001000);
    bus_ack(2, 64'd0, "sh");
    chk("sh_wmask_hold", {56'd0, dmem_wmask}, 64'hC0);
    chk("sh_valid", {63'd0, mem_valid}, 64'd1);
    chk("sh_rdata", mem_rdata,          64'd0);
    step();

    // misaligned LW: no bus request, valid next cycle with misalign flag
    drive(64'h80000110, I_LW, 64'h80001002, 64'd0);
    step();
    ex_valid = 1'b0;
    chk("lw_req",   {63'd0, dmem_req},     64'd0);
    chk("lw_valid", {63'd0, mem_valid},    64'd1);
    chk("lw_mis",   {63'd0, mem_misalign}, 64'd1);
    chk("lw_rdata", mem_rdata,             64'd0);
    step();

    // back-to-back LD with WB stalled 4 cycles in DONE
    wb_allowin = 1'b0;
    drive(64'h80000200, I_LD, 64'h80002000, 64'd0);
    step();
    drive(64'h80000204, I_LD, 64'h80002008, 64'd0);
    chk("ld1_addr", dmem_addr, 64'h80002000);
    bus_ack(1, 64'h11111111_11111111, "ld1");
    for (int i = 0; i < 4; i++) begin
      chk("ld1_hold_valid",   {63'd0, mem_valid},   64'd1);
      chk("ld1_hold_rdata",   mem_rdata,            64'h11111111_11111111);
      chk("ld1_hold_pc",      mem_pc,               64'h80000200);
      chk("ld1_hold_allowin", {63'd0, mem_allowin}, 64'd0);
      chk("ld1_hold_req",     {63'd0, dmem_req},    64'd0);
      step();
    end
    wb_allowin = 1'b1;
    #1;
    chk("ld_allowin", {63'd0, mem_allowin}, 64'd1);
    step();
    ex_valid = 1'b0;
    chk("ld2_req",  {63'd0, dmem_req},  64'd1);
    chk("ld2_addr", dmem_addr,          64'h80002008);
    chk("ld2_pc",   mem_pc,             64'h80000204);
    bus_ack(0, 64'h22222222_22222222, "ld2");
    chk("ld2_rdata", mem_rdata, 64'h22222222_22222222);
    step();

    // reset during BUS abandons the transaction; late ack ignored
    drive(64'h80000300, I_LB, 64'h80003000, 64'd0);
    step();
    ex_valid = 1'b0;
    chk("rb_req", {63'd0, dmem_req}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rb_req0",   {63'd0, dmem_req},  64'd0);
    chk("rb_valid0", {63'd0, mem_valid}, 64'd0);
    chk("rb_pc",     mem_pc,             64'h80000000);
    dmem_ack   = 1'b1;
    dmem_rdata = 64'h55;
    step();
    dmem_ack = 1'b0;
    chk("late_valid",   {63'd0, mem_valid},   64'd0);
    chk("late_rdata",   mem_rdata,            64'd0);
    chk("late_allowin", {63'd0, mem_allowin}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage of the 5-stage RV64 core.
- Accepts one instruction per handshake from the EX stage and classifies it as load, store or non-memory.
- Runs a req/ack transaction on the data-memory bus, formats the load data and presents the result to the MEM/WB pipeline register with a valid/allowin handshake.
- Is the producer of the MEM/WB register's mem_* inputs, its valid and its ena; ena = mem_valid & wb_allowin.

Parameters:
- RESET_PC, 64'h80000000, reset value of mem_pc.
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX stage holds a valid instruction
- mem_allowin  out  1  unit can accept from EX this cycle
- ex_pc  in  64  instruction PC
- ex_inst  in  32  instruction word; opcode [6:0], funct3 [14:12]
- ex_alu_result  in  64  effective address, or ALU result for non-memory instructions
- ex_store_data  in  64  rs2 value for stores
- ex_sel_rfres  in  2  writeback source select, passed through
- mem_valid  out  1  outputs hold a completed instruction
- wb_allowin  in  1  MEM/WB register accepts this cycle
- mem_pc  out  64  registered pass-through
- mem_inst  out  32  registered pass-through
- mem_alu_result  out  64  registered pass-through
- mem_sel_rfres  out  2  registered pass-through
- mem_rdata  out  64  formatted load data; 0 for non-loads
- mem_misalign  out  1  access was misaligned and no bus request was made
- dmem_req  out  1  bus request, held until ack
- dmem_wen  out  1  1 = store
- dmem_addr  out  64  {addr[63:3],3'b0}
- dmem_wdata  out  64  store data shifted to its byte lane
- dmem_wmask  out  8  byte enables
- dmem_ack  in  1  single-cycle completion
- dmem_rdata  in  64  read data, valid with ack

Behaviour:
- Reset values:
  - state = IDLE, mem_valid = 0, mem_pc = RESET_PC.
  - mem_inst, mem_alu_result, mem_sel_rfres, mem_rdata, mem_misalign all 0.
  - dmem_req = 0, dmem_wen = 0, dmem_addr/wdata/wmask = 0.
- States:
  - IDLE: empty.
  - BUS: dmem_req = 1.
  - DONE: mem_valid = 1.
- mem_allowin = (state==IDLE) | (state==DONE & wb_allowin).
- Accept = ex_valid & mem_allowin. On accept:
  - Latch pc, inst, alu_result, sel_rfres and the bus fields.
  - Load (opcode 0000011) or store (0100011), aligned: go to BUS.
  - Any other instruction, or a misaligned load/store: go to DONE, mem_rdata = 0.
  - mem_misalign = 1 for the misaligned memory case, 0 otherwise.
- Alignment: half needs addr[0]==0; word needs addr[1:0]==0; double needs addr[2:0]==0. Byte is always aligned.
- BUS: dmem_req and all dmem_* fields stay stable until dmem_ack. On the ack cycle:
  - Deassert req the next cycle.
  - Capture formatted rdata (loads only).
  - Go to DONE.
- DONE:
  - If wb_allowin: hand off. Next state is BUS/DONE on a simultaneous accept, else IDLE.
  - Else: hold all outputs.
- Latency, accept to mem_valid: non-memory 1 cycle; memory 2 + ack wait cycles.
- Load format: sh = 8*addr[2:0]; x = dmem_rdata >> sh.
  - LB/LH/LW sign-extend x[7:0]/[15:0]/[31:0].
  - LBU/LHU/LWU zero-extend.
  - LD takes x.
- Store format:
  - wdata = store_data << sh.
  - wmask = (8'h01/8'h03/8'h0F/8'hFF for SB/SH/SW/SD) << addr[2:0].
- A dmem_ack seen outside BUS is ignored.
- Reset during BUS: dmem_req drops the next cycle and the transaction is abandoned.
- wb_allowin low for N cycles in DONE: outputs unchanged for N cycles and no new accept.

Decomposition:
- Shared package core_pkg:
  - OPC_LOAD, OPC_STORE.
  - funct3 constants F3_B/H/W/D/BU/HU/WU.
  - mem_state_t {IDLE,BUS,DONE}.
  - RESET_PC.
- Sub-module mem_load_align: combinational (rdata, addr[2:0], funct3) -> formatted 64-bit data.

Test Plan:
- ADD inst, ex_alu_result=64'h1234, wb_allowin=1 -> mem_valid the next cycle, mem_alu_result=64'h1234, mem_rdata=0, dmem_req never asserted.
- LB at addr 64'h80001003, dmem_rdata=64'h00000000_80FF0000, ack after 3 cycles:
  - dmem_addr = 64'h80001000.
  - mem_rdata = 64'hFFFFFFFF_FFFFFF80.
  - LBU at the same address -> 64'h80.
- SH at addr 64'h80001006, store_data=64'hABCD -> dmem_wen=1, dmem_wmask=8'hC0, dmem_wdata=64'hABCD0000_00000000, req held until ack.
- LW at addr 64'h80001002 -> no dmem_req, mem_valid after 1 cycle, mem_misalign=1.
- Back-to-back LD, LD with wb_allowin=0 for 4 cycles in DONE:
  - First result is held stable.
  - mem_allowin=0.
  - Second request issues only after the handoff.
- Assert rst during BUS -> dmem_req=0 and mem_valid=0 the next cycle, mem_pc=64'h80000000; a late ack is ignored.
